// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add unsigned multiplier sequencer around one ripple-carry adder.
// One add/shift iteration per clock; product latched into P on completion.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             c_add;
  logic [WIDTH-1:0] acc_add;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic [CW-1:0]    count_n;
  logic             last;

  // Full-adder chain: acc + m, carry-in tied low
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = acc[i] ^ m[i] ^ carry[i];
    assign carry[i+1] = (acc[i] & m[i])
                      | (carry[i] & (acc[i] ^ m[i]));
  end

  // The carry lives only within one edge: it is shifted into acc MSB
  assign {c_add, acc_add} = q[0] ? {carry[WIDTH], sum}
                                 : {1'b0, acc};

  assign acc_sh  = {c_add, acc_add[WIDTH-1:1]};
  assign q_sh    = {acc_add[0], q[WIDTH-1:1]};
  assign count_n = count + CW'(1);
  assign last    = (count_n == CW'(WIDTH));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      count <= '0;
      P     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= A;
            q     <= B;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_sh;
          q     <= q_sh;
          count <= count_n;
          if (last) P <= {acc_sh, q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl.
// Directed corner cases plus randomized operations against a product model.
module tb_shift_add_mult_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .done     (done),
    .P        (p)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: quiet, 1: random operand/start noise, 2: FFxFF start pulse at cycle 3
  task automatic run_op(input logic [W-1:0] oa,
                        input logic [W-1:0] ob,
                        input bit hold,
                        input int mode);
    logic [31:0] exp;
    exp   = 32'(oa) * 32'(ob);
    a     = oa;
    b     = ob;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("busy_accept", 32'(busy), 32'(1));
    check("done_accept", 32'(done), 32'(0));
    for (int k = 1; k <= W; k++) begin
      if (mode == 1) begin
        a = 8'($urandom);
        b = 8'($urandom);
        if (!hold) start = 1'($urandom_range(0, 1));
      end else if (mode == 2 && k == 3) begin
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
      end
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      check("busy_run", 32'(busy), 32'(1));
      check("done_run", 32'(done), 32'(k == W));
    end
    check("product", 32'(p), exp);
    @(posedge clk); #1;
    check("busy_idle", 32'(busy), 32'(0));
    check("done_idle", 32'(done), 32'(0));
    check("product_hold", 32'(p), exp);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_p", 32'(p), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(8'h0D, 8'h0B, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'h00, 8'hA5, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h0D, 8'h0B, 1'b0, 2);

    // abort in the middle of a run
    a     = 8'h0D;
    b     = 8'h0B;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_p", 32'(p), 32'(0));
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_abort_done", 32'(done), 32'(0));
    run_op(8'h02, 8'h03, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // start held high: back-to-back ops every W+2 cycles
    for (int i = 0; i < 5; i++)
      run_op(8'($urandom), 8'($urandom), 1'b1, 1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
